// File: rtl/rv32_pkg.sv
// Shared writeback-stage types: load funct3 encodings, pending-result entry,
// stage state and the load-data extraction helper.
package rv32_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] alu_result;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RETIRE   = 2'd1,
    WAIT_MEM = 2'd2
  } wb_state_e;

  // Unknown funct3 codes fall back to a full-word load.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      LB:      return {{24{b[7]}}, b};
      LH:      return {{16{h[15]}}, h};
      LBU:     return {24'd0, b};
      LHU:     return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/rv32_wb_fifo.sv
// In-order pending-result FIFO; the whole entry array and per-slot valid
// mask are exposed so the stage can build its register scoreboard.
module rv32_wb_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      entry_vld
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  wb_entry_t [DEPTH-1:0] mem;
  logic                  do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Payload storage carries no reset; validity comes from the pointers only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;

  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [AW-1:0] off;
    assign off          = AW'(g) - rd_ptr;
    assign entry_vld[g] = ({1'b0, off} < count);
  end

endmodule

// File: rtl/rv32_writeback_stage.sv
// RV32 writeback stage: buffers MEM results in order, waits on load data,
// extends it, and drives a registered register-file write port.
module rv32_writeback_stage
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        write_reg,
  output logic [4:0]  sel_d1,
  output logic [31:0] reg_d1,
  output logic [31:0] rd_busy,
  output logic [31:0] retired_count,
  output logic        err_unexpected_rdata
);

  wb_entry_t             push_data, head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      entry_vld;
  logic                  full, empty, push, pop, unexpected;
  logic [31:0]           wb_data;
  wb_state_e             state;

  assign push_data = '{rd: in_rd, wen: in_wen, is_load: in_is_load,
                       funct3: in_funct3, addr_lo: in_addr_lo,
                       alu_result: in_alu_result};

  // Full blocks accept even when the head retires this cycle.
  assign in_ready = !full;
  assign push     = in_valid && !full;

  rv32_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .entries   (entries),
    .entry_vld (entry_vld)
  );

  // State follows the head entry and this cycle's memory response.
  always_comb begin
    state = IDLE;
    if (!empty) state = (head.is_load && !mem_rvalid) ? WAIT_MEM : RETIRE;
  end

  assign pop        = (state == RETIRE);
  assign unexpected = mem_rvalid && !(state == RETIRE && head.is_load);
  assign wb_data    = head.is_load ? load_extend(head.funct3, head.addr_lo, mem_rdata)
                                   : head.alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_reg            <= 1'b0;
      sel_d1               <= '0;
      reg_d1               <= '0;
      retired_count        <= '0;
      err_unexpected_rdata <= 1'b0;
    end else begin
      write_reg <= pop && head.wen && (head.rd != 5'd0);
      if (pop) begin
        sel_d1        <= head.rd;
        reg_d1        <= wb_data;
        retired_count <= retired_count + 32'd1;
      end
      if (unexpected) err_unexpected_rdata <= 1'b1;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && entries[i].wen) rd_busy[entries[i].rd] = 1'b1;
    end
    rd_busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_rv32_writeback_stage.sv
// Self-checking bench for rv32_writeback_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_rv32_writeback_stage;
  import rv32_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen, in_is_load;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        write_reg;
  logic [4:0]  sel_d1;
  logic [31:0] reg_d1, rd_busy, retired_count;
  logic        err_unexpected_rdata;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] alu;
  } op_t;

  always #5 clk = ~clk;

  rv32_writeback_stage #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_rd                (in_rd),
    .in_wen               (in_wen),
    .in_is_load           (in_is_load),
    .in_funct3            (in_funct3),
    .in_addr_lo           (in_addr_lo),
    .in_alu_result        (in_alu_result),
    .mem_rvalid           (mem_rvalid),
    .mem_rdata            (mem_rdata),
    .write_reg            (write_reg),
    .sel_d1               (sel_d1),
    .reg_d1               (reg_d1),
    .rd_busy              (rd_busy),
    .retired_count        (retired_count),
    .err_unexpected_rdata (err_unexpected_rdata)
  );

  // Load result from the ISA rules, written arithmetically.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    int unsigned b, h, o;
    o = off;
    b = (d >> (8 * o)) & 32'hFF;
    h = (d >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_rd = 0; in_wen = 0; in_is_load = 0; in_funct3 = 0;
    in_addr_lo = 0; in_alu_result = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic drive_op(input logic [4:0] rd, input logic wen, input logic ld,
                          input logic [2:0] f3, input logic [1:0] off, input logic [31:0] alu);
    in_valid = 1; in_rd = rd; in_wen = wen; in_is_load = ld;
    in_funct3 = f3; in_addr_lo = off; in_alu_result = alu;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (write_reg !== 1'b0) begin errors++; $display("FAIL reset_write_reg got %b want 0", write_reg); end
    checks++; if (sel_d1 !== 5'd0) begin errors++; $display("FAIL reset_sel_d1 got %0d want 0", sel_d1); end
    checks++; if (reg_d1 !== 32'd0) begin errors++; $display("FAIL reset_reg_d1 got %h want 0", reg_d1); end
    checks++; if (rd_busy !== 32'd0) begin errors++; $display("FAIL reset_rd_busy got %h want 0", rd_busy); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", retired_count); end
    checks++; if (err_unexpected_rdata !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_unexpected_rdata); end
    rst = 0; exp_cnt = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_alu();
    drive_op(5'd5, 1, 0, LW, 0, 32'h12345678);
    tick();
    idle_inputs();
    checks++; if (rd_busy[5] !== 1'b1 || write_reg !== 1'b0) begin errors++; $display("FAIL alu_cycle1 busy5=%b wr=%b want 1/0", rd_busy[5], write_reg); end
    tick();
    exp_cnt++;
    checks++; if (write_reg !== 1'b1 || sel_d1 !== 5'd5 || reg_d1 !== 32'h12345678) begin
      errors++; $display("FAIL alu_write got wr=%b sel=%0d d=%h want 1/5/12345678", write_reg, sel_d1, reg_d1); end
    checks++; if (retired_count !== 32'(exp_cnt)) begin errors++; $display("FAIL alu_count got %0d want %0d", retired_count, exp_cnt); end
    checks++; if (rd_busy[5] !== 1'b0) begin errors++; $display("FAIL alu_busy_clear got %b want 0", rd_busy[5]); end
    tick();
    checks++; if (write_reg !== 1'b0) begin errors++; $display("FAIL alu_one_cycle got %b want 0", write_reg); end
  endtask

  task automatic test_load_order();
    drive_op(5'd3, 1, 1, LW, 0, 32'h0);
    tick();
    drive_op(5'd4, 1, 0, LW, 0, 32'hAA);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      checks++; if (rd_busy[3] !== 1'b1 || rd_busy[4] !== 1'b1 || write_reg !== 1'b0) begin
        errors++; $display("FAIL ldord_wait c=%0d busy3=%b busy4=%b wr=%b want 1/1/0", c, rd_busy[3], rd_busy[4], write_reg); end
      tick();
    end
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 0;
    checks++; if (write_reg !== 1'b1 || sel_d1 !== 5'd3 || reg_d1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL ldord_load got wr=%b sel=%0d d=%h want 1/3/deadbeef", write_reg, sel_d1, reg_d1); end
    checks++; if (rd_busy[3] !== 1'b0 || rd_busy[4] !== 1'b1) begin
      errors++; $display("FAIL ldord_busy_mid busy3=%b busy4=%b want 0/1", rd_busy[3], rd_busy[4]); end
    tick();
    exp_cnt += 2;
    checks++; if (write_reg !== 1'b1 || sel_d1 !== 5'd4 || reg_d1 !== 32'hAA) begin
      errors++; $display("FAIL ldord_alu got wr=%b sel=%0d d=%h want 1/4/aa", write_reg, sel_d1, reg_d1); end
    checks++; if (rd_busy !== 32'd0 || retired_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL ldord_end busy=%h cnt=%0d want 0/%0d", rd_busy, retired_count, exp_cnt); end
  endtask

  task automatic test_extension();
    logic [2:0]  f3s [4] = '{LB, LBU, LH, LHU};
    logic [1:0]  offs[4] = '{2'd0, 2'd3, 2'd2, 2'd0};
    logic [31:0] exps[4] = '{32'hFFFFFF81, 32'h00000080, 32'hFFFF80F0, 32'h00007F81};
    for (int i = 0; i < 4; i++) begin
      drive_op(5'd7, 1, 1, f3s[i], offs[i], 32'h0);
      tick();
      idle_inputs();
      mem_rvalid = 1; mem_rdata = 32'h80F07F81;
      tick();
      mem_rvalid = 0;
      exp_cnt++;
      checks++; if (write_reg !== 1'b1 || reg_d1 !== exps[i]) begin
        errors++; $display("FAIL ext_%0d got wr=%b d=%h want 1/%h", i, write_reg, reg_d1, exps[i]); end
    end
  endtask

  task automatic test_full();
    logic [4:0] rds[4] = '{5'd0, 5'd9, 5'd10, 5'd11};
    for (int i = 0; i < 4; i++) begin
      drive_op(rds[i], 1, 1, LW, 0, 32'h0);
      tick();
    end
    idle_inputs();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", in_ready); end
    checks++; if (rd_busy !== 32'h00000E00) begin errors++; $display("FAIL full_busy got %h want 00000e00", rd_busy); end
    drive_op(5'd12, 1, 0, LW, 0, 32'h55);
    mem_rvalid = 1; mem_rdata = 32'h1111;
    tick();
    idle_inputs();
    exp_cnt++;
    checks++; if (write_reg !== 1'b0 || retired_count !== 32'(exp_cnt)) begin
      errors++; $display("FAIL full_silent got wr=%b cnt=%0d want 0/%0d", write_reg, retired_count, exp_cnt); end
    checks++; if (in_ready !== 1'b1 || rd_busy[12] !== 1'b0) begin
      errors++; $display("FAIL full_no_accept got ready=%b busy12=%b want 1/0", in_ready, rd_busy[12]); end
    for (int i = 1; i < 4; i++) begin
      mem_rvalid = 1; mem_rdata = 32'h100 * i;
      tick();
      mem_rvalid = 0;
      exp_cnt++;
      checks++; if (write_reg !== 1'b1 || sel_d1 !== rds[i] || reg_d1 !== 32'h100 * i) begin
        errors++; $display("FAIL full_drain_%0d got wr=%b sel=%0d d=%h", i, write_reg, sel_d1, reg_d1); end
    end
    checks++; if (rd_busy !== 32'd0 || err_unexpected_rdata !== 1'b0) begin
      errors++; $display("FAIL full_end busy=%h err=%b want 0/0", rd_busy, err_unexpected_rdata); end
  endtask

  task automatic test_error_reset();
    mem_rvalid = 1; mem_rdata = 32'hCAFE;
    tick();
    mem_rvalid = 0;
    checks++; if (err_unexpected_rdata !== 1'b1 || write_reg !== 1'b0) begin
      errors++; $display("FAIL err_set got err=%b wr=%b want 1/0", err_unexpected_rdata, write_reg); end
    tick(); tick();
    checks++; if (err_unexpected_rdata !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_unexpected_rdata); end
    drive_op(5'd13, 1, 1, LW, 0, 0); tick();
    drive_op(5'd14, 1, 1, LW, 0, 0); tick();
    idle_inputs();
    checks++; if (rd_busy !== 32'h00006000) begin errors++; $display("FAIL err_pending_busy got %h want 00006000", rd_busy); end
    rst = 1;
    #1;
    checks++; if (rd_busy !== 32'd0 || retired_count !== 32'd0 || err_unexpected_rdata !== 1'b0) begin
      errors++; $display("FAIL async_rst busy=%h cnt=%0d err=%b want 0/0/0", rd_busy, retired_count, err_unexpected_rdata); end
    @(negedge clk);
    rst = 0; exp_cnt = 0;
    tick();
    checks++; if (in_ready !== 1'b1 || rd_busy !== 32'd0) begin
      errors++; $display("FAIL rst_after ready=%b busy=%h want 1/0", in_ready, rd_busy); end
    mem_rvalid = 1; mem_rdata = 32'hBEEF;
    tick();
    mem_rvalid = 0;
    checks++; if (err_unexpected_rdata !== 1'b1 || write_reg !== 1'b0) begin
      errors++; $display("FAIL rst_discard err=%b wr=%b want 1/0", err_unexpected_rdata, write_reg); end
    rst = 1; tick(); rst = 0; tick();
  endtask

  task automatic test_random();
    op_t         q[$];
    op_t         h, o;
    logic        pend_w = 0;
    logic [4:0]  pend_rd = 0;
    logic [31:0] pend_val = 0;
    logic [31:0] mb;
    int          retired = 0;
    bit          acc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (write_reg !== pend_w || (pend_w && (sel_d1 !== pend_rd || reg_d1 !== pend_val))) begin
        errors++; $display("FAIL rnd_write cyc=%0d got wr=%b sel=%0d d=%h want %b/%0d/%h",
                           cyc, write_reg, sel_d1, reg_d1, pend_w, pend_rd, pend_val); end
      checks++; if (in_ready !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, in_ready, q.size() < DEPTH); end
      mb = 0;
      foreach (q[k]) if (q[k].wen && q[k].rd != 0) mb[q[k].rd] = 1'b1;
      checks++; if (rd_busy !== mb) begin
        errors++; $display("FAIL rnd_busy cyc=%0d got %h want %h", cyc, rd_busy, mb); end
      drive_op(5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
      in_valid   = ($urandom_range(0, 99) < 60);
      mem_rvalid = (q.size() > 0) && q[0].ld && ($urandom_range(0, 1) == 1);
      mem_rdata  = $urandom;
      @(posedge clk);
      acc    = in_valid && (q.size() < DEPTH);
      pend_w = 0;
      if (q.size() > 0 && (!q[0].ld || mem_rvalid)) begin
        h = q.pop_front();
        retired++;
        pend_w   = h.wen && (h.rd != 0);
        pend_rd  = h.rd;
        pend_val = h.ld ? ref_load(h.f3, h.off, mem_rdata) : h.alu;
      end
      if (acc) begin
        o = '{rd: in_rd, wen: in_wen, ld: in_is_load, f3: in_funct3, off: in_addr_lo, alu: in_alu_result};
        q.push_back(o);
      end
      @(negedge clk);
    end
    idle_inputs();
    checks++; if (retired_count !== 32'(retired) || err_unexpected_rdata !== 1'b0) begin
      errors++; $display("FAIL rnd_count got cnt=%0d err=%b want %0d/0", retired_count, err_unexpected_rdata, retired); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_load_order();
    test_extension();
    test_full();
    test_error_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_writeback_stage.md
RV32_WRITEBACK_STAGE -- requirements
Module: rv32_writeback_stage

Interface
REQ-001 Parameter DEPTH, default 4, number of in-order pending-result entries (power of two, >=2).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  MEM stage presents a result; in_ready  out  1  stage can accept.
REQ-005 in_rd  in  5  destination register; in_wen  in  1  instruction writes rd.
REQ-006 in_is_load  in  1  result comes from the memory response, not in_alu_result.
REQ-007 in_funct3  in  3  load type; in_addr_lo  in  2  load byte offset; in_alu_result  in  32  non-load result.
REQ-008 mem_rvalid  in  1  load data valid this cycle; mem_rdata  in  32  raw aligned-word load data.
REQ-009 write_reg  out  1, sel_d1  out  5, reg_d1  out  32: register-file write port.
REQ-010 rd_busy  out  32  per-register pending-write scoreboard for decode hazard checks.
REQ-011 retired_count  out  32  retired-instruction counter; err_unexpected_rdata  out  1  sticky protocol error.

Function
REQ-012 Accept occurs when in_valid && in_ready; accepted fields are pushed into an in-order FIFO of DEPTH entries.
REQ-013 in_ready SHALL equal !full; when full, no accept even if the head retires the same cycle.
REQ-014 Simultaneous accept and retire when not full: both occur, occupancy unchanged.
REQ-015 FSM states: IDLE (FIFO empty), RETIRE (head is non-load, or load with mem_rvalid high), WAIT_MEM (head is load, mem_rvalid low).
REQ-016 Head retires in the cycle its state is RETIRE; an entry accepted at cycle N retires no earlier than cycle N+1.
REQ-017 Retire at cycle N drives write_reg/sel_d1/reg_d1 registered during cycle N+1 for exactly one cycle.
REQ-018 write_reg SHALL be 1 only if head wen=1 and rd!=0; otherwise the entry retires silently (write_reg 0).
REQ-019 Retirement strictly in program order; a non-load behind a waiting load waits.
REQ-020 Load data selection: byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16].
REQ-021 funct3 000 LB sign-extend byte; 001 LH sign-extend half; 010 LW full word; 100 LBU zero-extend; 101 LHU zero-extend; others treated as LW.
REQ-022 mem_rvalid high while state is not WAIT_MEM/RETIRE-with-load-head: data dropped, err_unexpected_rdata set and held until reset.
REQ-023 rd_busy[i] =1 iff any valid FIFO entry has wen=1 and rd=i, i!=0; rd_busy[0] always 0; combinational from FIFO contents.
REQ-024 retired_count increments by 1 per retired entry (including silent retires), wraps 0xFFFFFFFF->0.
REQ-025 Pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or count.

Reset
REQ-026 rst asserted: FIFO emptied, state IDLE, in_ready 1 after release, write_reg 0, sel_d1 0, reg_d1 0, rd_busy 0, retired_count 0, err_unexpected_rdata 0.
REQ-027 rst mid-operation (pending loads) discards all entries; a later mem_rvalid with empty FIFO sets err_unexpected_rdata.
REQ-028 FIFO data storage need not be reset; only valid/pointer state.

Structure
REQ-029 Shared package rv32_pkg holds load funct3 constants (LB, LH, LW, LBU, LHU) and wb_entry_t struct (rd, wen, is_load, funct3, addr_lo, alu_result).
REQ-030 FIFO implemented as sub-module rv32_wb_fifo (parameterised sync FIFO, push/pop/full/empty, exposed entry array for scoreboard).

Verification
REQ-031 ALU: accept rd=5, wen=1, alu=0x12345678 at cycle 0 -> write_reg=1, sel_d1=5, reg_d1=0x12345678 at cycle 2; retired_count=1.
REQ-032 Load ordering: LW rd=3 then ALU rd=4 (0xAA); mem_rvalid 5 cycles later with 0xDEADBEEF -> rd3=0xDEADBEEF written, rd4=0xAA written the next cycle; rd_busy[3], rd_busy[4] high until each retires.
REQ-033 Extension: mem_rdata=0x80F0_7F81; LB addr_lo=0 -> 0xFFFFFF81; LBU addr_lo=3 -> 0x00000080; LH addr_lo=2 -> 0xFFFF80F0; LHU addr_lo=0 -> 0x00007F81.
REQ-034 Full: DEPTH=4 loads accepted, no mem_rvalid -> in_ready=0; one mem_rvalid -> in_ready=1 next cycle; rd=0 load retires with write_reg=0.
REQ-035 Errors/reset: mem_rvalid with empty FIFO -> err_unexpected_rdata=1 sticky; rst pulse with 2 pending loads -> rd_busy=0, retired_count=0, error cleared.
